// File: rtl/prgrm_cnt_stack.sv
// Program counter with a hardware return-address stack.
// One PC update per clock: hold, increment, jump/call, or return.
module prgrm_cnt_stack #(
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 8,
    parameter int RESET_VEC   = 0
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Stall,
    input  logic              Incrmnt_PC,
    input  logic              Ld_Brnch_Addr,
    input  logic              Ld_Rtn_Addr,
    input  logic [31:0]       Crnt_Instrn,
    output logic [ADDR_W-1:0] PC,
    output logic              Stack_Empty,
    output logic              Stack_Full,
    output logic              Stk_Ovfl,
    output logic              Stk_Unfl
);

    localparam int CNT_W = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = $clog2(STACK_DEPTH);

    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(STACK_DEPTH);
    localparam logic [ADDR_W-1:0] RST_PC   = ADDR_W'(RESET_VEC);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovfl_q, ovfl_d;
    logic              unfl_q, unfl_d;

    logic [ADDR_W-1:0] stack_q [STACK_DEPTH];

    logic              push_en;
    logic [IDX_W-1:0]  push_idx;
    logic [IDX_W-1:0]  pop_idx;
    logic [ADDR_W-1:0] pc_inc;
    logic              empty;
    logic              full;
    logic              is_call;

    // Upper instruction bits belong to other decode paths.
    logic unused_instrn;
    assign unused_instrn = ^{Crnt_Instrn[31:29], Crnt_Instrn[27:ADDR_W]};

    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == FULL_CNT);
    assign is_call  = Crnt_Instrn[28];
    assign pc_inc   = pc_q + 1'b1;
    assign push_idx = cnt_q[IDX_W-1:0];
    assign pop_idx  = push_idx - 1'b1;

    always_comb begin
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        ovfl_d  = ovfl_q;
        unfl_d  = unfl_q;
        push_en = 1'b0;
        if (!Stall) begin
            if (Ld_Rtn_Addr) begin
                if (empty) begin
                    unfl_d = 1'b1;
                end else begin
                    pc_d  = stack_q[pop_idx];
                    cnt_d = cnt_q - 1'b1;
                end
            end else if (Ld_Brnch_Addr) begin
                pc_d = Crnt_Instrn[ADDR_W-1:0];
                if (is_call) begin
                    if (full) begin
                        ovfl_d = 1'b1;
                    end else begin
                        push_en = 1'b1;
                        cnt_d   = cnt_q + 1'b1;
                    end
                end
            end else if (Incrmnt_PC) begin
                pc_d = pc_inc;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc_q   <= RST_PC;
            cnt_q  <= '0;
            ovfl_q <= 1'b0;
            unfl_q <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            cnt_q  <= cnt_d;
            ovfl_q <= ovfl_d;
            unfl_q <= unfl_d;
        end
    end

    // Stack storage is deliberately left untouched by Reset.
    always_ff @(posedge Clk) begin
        if (!Reset && push_en) begin
            stack_q[push_idx] <= pc_inc;
        end
    end

    assign PC          = pc_q;
    assign Stack_Empty = empty;
    assign Stack_Full  = full;
    assign Stk_Ovfl    = ovfl_q;
    assign Stk_Unfl    = unfl_q;

endmodule

// File: tb/tb_prgrm_cnt_stack.sv
// Directed self-checking bench for prgrm_cnt_stack.
module tb_prgrm_cnt_stack;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        Stall = 1'b0;
    logic        Incrmnt_PC = 1'b0;
    logic        Ld_Brnch_Addr = 1'b0;
    logic        Ld_Rtn_Addr = 1'b0;
    logic [31:0] Crnt_Instrn = '0;
    logic [7:0]  PC;
    logic        Stack_Empty;
    logic        Stack_Full;
    logic        Stk_Ovfl;
    logic        Stk_Unfl;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] CALL = 32'h1000_0000;

    prgrm_cnt_stack #(
        .ADDR_W(8),
        .STACK_DEPTH(8),
        .RESET_VEC(0)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .Stall(Stall),
        .Incrmnt_PC(Incrmnt_PC),
        .Ld_Brnch_Addr(Ld_Brnch_Addr),
        .Ld_Rtn_Addr(Ld_Rtn_Addr),
        .Crnt_Instrn(Crnt_Instrn),
        .PC(PC),
        .Stack_Empty(Stack_Empty),
        .Stack_Full(Stack_Full),
        .Stk_Ovfl(Stk_Ovfl),
        .Stk_Unfl(Stk_Unfl)
    );

    always #5 Clk = ~Clk;

    task automatic cyc(input logic rst, input logic stl, input logic rtn,
                       input logic brn, input logic inc,
                       input logic [31:0] ins);
        Reset         = rst;
        Stall         = stl;
        Ld_Rtn_Addr   = rtn;
        Ld_Brnch_Addr = brn;
        Incrmnt_PC    = inc;
        Crnt_Instrn   = ins;
        @(posedge Clk);
        #1;
        Reset         = 1'b0;
        Stall         = 1'b0;
        Ld_Rtn_Addr   = 1'b0;
        Ld_Brnch_Addr = 1'b0;
        Incrmnt_PC    = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_st(input string tag, input logic [7:0] pc,
                          input logic e, input logic f,
                          input logic o, input logic u);
        chk({tag, ".pc"}, {24'h0, PC}, {24'h0, pc});
        chk({tag, ".empty"}, {31'h0, Stack_Empty}, {31'h0, e});
        chk({tag, ".full"}, {31'h0, Stack_Full}, {31'h0, f});
        chk({tag, ".ovfl"}, {31'h0, Stk_Ovfl}, {31'h0, o});
        chk({tag, ".unfl"}, {31'h0, Stk_Unfl}, {31'h0, u});
    endtask

    initial begin
        logic [7:0] exp_pc;

        // 1. reset
        cyc(1, 0, 0, 0, 0, 0);
        chk_st("reset", 8'h00, 1, 0, 0, 0);

        // 2. increment across the wrap
        for (int i = 1; i <= 256; i++) begin
            cyc(0, 0, 0, 0, 1, 0);
            exp_pc = 8'(i);
            chk("inc.pc", {24'h0, PC}, {24'h0, exp_pc});
        end
        chk_st("inc.wrap", 8'h00, 1, 0, 0, 0);

        // idle holds
        cyc(0, 0, 0, 0, 0, 0);
        chk_st("idle", 8'h00, 1, 0, 0, 0);

        // 3. jump, call, return
        cyc(0, 0, 0, 1, 0, 32'h0000_0010);
        chk_st("jump", 8'h10, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, CALL | 32'h40);
        chk_st("call", 8'h40, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        chk_st("ret", 8'h11, 1, 0, 0, 0);

        // 4. nested calls to overflow, then unwind
        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, 0, 1, 0, CALL | 32'(8'h50 + i));
            chk_st("ncall", 8'(8'h50 + i), 0, (i == 7), 0, 0);
        end
        cyc(0, 0, 0, 1, 0, CALL | 32'h58);
        chk_st("ovfl", 8'h58, 0, 1, 1, 0);
        for (int i = 7; i >= 1; i--) begin
            cyc(0, 0, 1, 0, 0, 0);
            chk_st("nret", 8'(8'h50 + i), 0, 0, 1, 0);
        end
        cyc(0, 0, 1, 0, 0, 0);
        chk_st("nret.last", 8'h12, 1, 0, 1, 0);

        // 5. return while empty; branch in same cycle ignored
        cyc(0, 0, 0, 1, 0, 32'h22);
        chk_st("jump22", 8'h22, 1, 0, 1, 0);
        cyc(0, 0, 1, 1, 0, CALL | 32'h99);
        chk_st("unfl", 8'h22, 1, 0, 1, 1);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1, 0);
        chk_st("sticky", 8'h24, 1, 0, 1, 1);
        cyc(1, 0, 0, 0, 0, 0);
        chk_st("reset2", 8'h00, 1, 0, 0, 0);

        // 6a. all controls high with count=1: pop only
        cyc(0, 0, 0, 1, 0, CALL | 32'h30);
        chk_st("6a.call", 8'h30, 0, 0, 0, 0);
        cyc(0, 0, 1, 1, 1, CALL | 32'h70);
        chk_st("6a.pop", 8'h01, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        chk_st("6a.nopush", 8'h01, 1, 0, 0, 1);
        cyc(1, 0, 0, 0, 0, 0);

        // 6b. stall drops every control
        cyc(0, 0, 0, 1, 0, 32'h33);
        cyc(0, 0, 0, 1, 0, CALL | 32'h60);
        chk_st("6b.pre", 8'h60, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0);
        chk_st("6b.rtn", 8'h60, 0, 0, 0, 0);
        cyc(0, 1, 0, 1, 0, CALL | 32'h77);
        chk_st("6b.call", 8'h60, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 1, 0);
        chk_st("6b.inc", 8'h60, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        chk_st("6b.ret", 8'h34, 1, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0);
        chk_st("6b.noufl", 8'h34, 1, 0, 0, 0);

        // 6c. reset after three pushes
        cyc(0, 0, 0, 1, 0, CALL | 32'h80);
        cyc(0, 0, 0, 1, 0, CALL | 32'h90);
        cyc(0, 0, 0, 1, 0, CALL | 32'hA0);
        chk_st("6c.pre", 8'hA0, 0, 0, 0, 0);
        cyc(1, 0, 1, 1, 1, CALL | 32'hB0);
        chk_st("6c.rst", 8'h00, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        chk_st("6c.empty", 8'h00, 1, 0, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
